// File: rtl/fir_mc_tdm_filter.sv
// Multichannel time-multiplexed FIR: per-channel delay lines, NMULT shared multipliers, optional pre-add.
// Define FIR_MC_ROUND_SAT_EN for half-up rounding and saturation on the output; otherwise truncate and wrap.
module fir_mc_tdm_filter #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 24,
    parameter int OUT_W     = 24,
    parameter int ACC_W     = 64,
    parameter int NTAPS     = 65,
    parameter int NCH       = 4,
    parameter int CH_W      = 4,
    parameter int NMULT     = 8,
    parameter int OUT_SHIFT = 23
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cfg_start,
    input  logic                     cfg_sym,
    input  logic [COEF_W-1:0]        cfg_data,
    input  logic                     cfg_valid,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    input  logic signed [DATA_W-1:0] din,
    input  logic [CH_W-1:0]          din_ch,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [OUT_W-1:0]         dout,
    output logic [CH_W-1:0]          dout_ch,
    output logic                     dout_valid,
    output logic                     dout_ovf,
    output logic [2:0]               dbg_state
);
    localparam int HALF   = (NTAPS + 1) / 2;
    localparam int OP_W   = DATA_W + 1;
    localparam int PROD_W = COEF_W + DATA_W + 1;
    localparam int CNT_W  = $clog2(NTAPS + 1);
    localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int LCH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] P_GEN  = CNT_W'(NTAPS);
    localparam logic [CNT_W-1:0] P_SYM  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] IT_GEN = CNT_W'((NTAPS + NMULT - 1) / NMULT);
    localparam logic [CNT_W-1:0] IT_SYM = CNT_W'((HALF + NMULT - 1) / NMULT);
    localparam logic [CH_W:0]    NCH_L  = (CH_W + 1)'(NCH);

    typedef enum logic [2:0] {S_UNCFG, S_CFG, S_READY, S_MAC, S_FLUSH, S_OUT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic                       sym_q, sym_d, pend_q, pend_d, pend_sym_q, pend_sym_d;
    logic                       cfg_done_q, cfg_done_d, dout_valid_q, dout_valid_d;
    logic                       dout_ovf_q, dout_ovf_d;
    logic [OUT_W-1:0]           dout_q, dout_d, scaled;
    logic [CH_W-1:0]            dout_ch_q, dout_ch_d;
    logic                       scaled_ovf, coef_we, lines_clr, shift_we, acc_clr;
    logic signed [COEF_W-1:0]   coef_q [NTAPS];
    logic signed [DATA_W-1:0]   x_q [NCH][NTAPS];
    logic signed [OP_W-1:0]     opx_q [NMULT], opx_d [NMULT];
    logic signed [COEF_W-1:0]   opc_q [NMULT], opc_d [NMULT];
    logic signed [PROD_W-1:0]   prod_q [NMULT], prod_d [NMULT];
    logic signed [ACC_W-1:0]    acc_q, acc_d, lane_sum;
    logic [TAP_W-1:0]           lo_idx [NMULT], hi_idx [NMULT];
    logic                       lane_on [NMULT], lane_pair [NMULT];
    logic [CNT_W-1:0]           p_words, iter_n;
    logic [LCH_W-1:0]           ch_idx;
    logic                       xfer, ch_ok;

    assign p_words    = sym_q ? P_SYM : P_GEN;
    assign iter_n     = sym_q ? IT_SYM : IT_GEN;
    assign ch_idx     = LCH_W'(ch_q);
    assign din_ready  = (state_q == S_READY);
    assign cfg_busy   = (state_q == S_CFG);
    assign xfer       = din_valid && din_ready;
    assign ch_ok      = ({1'b0, din_ch} < NCH_L);
    assign cfg_done   = cfg_done_q;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign dout_ovf   = dout_ovf_q;
    assign dbg_state  = state_q;

    // Lane l of iteration cnt_q handles operand index cnt_q*NMULT+l; lanes past P carry zeros.
    always_comb begin
        for (int l = 0; l < NMULT; l++) begin
            lane_on[l]   = (state_q == S_MAC) && ((int'(cnt_q) * NMULT + l) < int'(p_words));
            lane_pair[l] = sym_q && ((int'(cnt_q) * NMULT + l) < HALF - 1);
            lo_idx[l]    = TAP_W'(int'(cnt_q) * NMULT + l);
            hi_idx[l]    = TAP_W'(NTAPS - 1 - (int'(cnt_q) * NMULT + l));
            opx_d[l]     = '0;
            opc_d[l]     = '0;
            if (lane_on[l]) begin
                opc_d[l] = coef_q[lo_idx[l]];
                if (lane_pair[l])
                    opx_d[l] = OP_W'(x_q[ch_idx][lo_idx[l]]) + OP_W'(x_q[ch_idx][hi_idx[l]]);
                else
                    opx_d[l] = OP_W'(x_q[ch_idx][lo_idx[l]]);
            end
            prod_d[l] = PROD_W'(opx_q[l]) * PROD_W'(opc_q[l]);
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < NMULT; l++) lane_sum = lane_sum + ACC_W'(prod_q[l]);
        acc_d = acc_clr ? '0 : acc_q + lane_sum;
    end

`ifdef FIR_MC_ROUND_SAT_EN
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] RND = (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
    logic signed [ACC_W-1:0] rnd_val;
    always_comb begin
        rnd_val    = (acc_d + RND) >>> OUT_SHIFT;
        scaled     = OUT_W'(rnd_val);
        scaled_ovf = 1'b0;
        if (rnd_val > OMAX) begin
            scaled     = OUT_W'(OMAX);
            scaled_ovf = 1'b1;
        end else if (rnd_val < OMIN) begin
            scaled     = OUT_W'(OMIN);
            scaled_ovf = 1'b1;
        end
    end
`else
    always_comb begin
        scaled     = OUT_W'(acc_d >>> OUT_SHIFT);
        scaled_ovf = 1'b0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        sym_d        = sym_q;
        pend_d       = pend_q;
        pend_sym_d   = pend_sym_q;
        cfg_done_d   = 1'b0;
        dout_valid_d = 1'b0;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_ovf_d   = dout_ovf_q;
        coef_we      = 1'b0;
        lines_clr    = 1'b0;
        shift_we     = 1'b0;
        acc_clr      = 1'b0;
        // A load request arriving mid-sample is remembered and served once the result is out.
        if (cfg_start && (state_q == S_MAC || state_q == S_FLUSH)) begin
            pend_d     = 1'b1;
            pend_sym_d = cfg_sym;
        end
        case (state_q)
            S_UNCFG: if (cfg_start) begin
                state_d = S_CFG;
                sym_d   = cfg_sym;
                cnt_d   = '0;
            end
            S_CFG: if (cfg_valid) begin
                coef_we = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == p_words - CNT_W'(1)) begin
                    lines_clr  = 1'b1;
                    cfg_done_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_READY;
                end
            end
            S_READY: begin
                if (xfer && ch_ok) begin
                    shift_we = 1'b1;
                    acc_clr  = 1'b1;
                    ch_d     = din_ch;
                    cnt_d    = '0;
                    state_d  = S_MAC;
                    if (cfg_start) begin
                        pend_d     = 1'b1;
                        pend_sym_d = cfg_sym;
                    end
                end else if (cfg_start) begin
                    state_d = S_CFG;
                    sym_d   = cfg_sym;
                    cnt_d   = '0;
                end
            end
            S_MAC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == iter_n - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d        = '0;
                    state_d      = S_OUT;
                    dout_valid_d = 1'b1;
                    dout_d       = scaled;
                    dout_ovf_d   = scaled_ovf;
                    dout_ch_d    = ch_q;
                end
            end
            S_OUT: begin
                state_d = S_READY;
                if (cfg_start || pend_q) begin
                    state_d = S_CFG;
                    sym_d   = cfg_start ? cfg_sym : pend_sym_q;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_UNCFG;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_UNCFG;
            cnt_q        <= '0;
            ch_q         <= '0;
            sym_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_sym_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_ovf_q   <= 1'b0;
            acc_q        <= '0;
            for (int l = 0; l < NMULT; l++) begin
                opx_q[l]  <= '0;
                opc_q[l]  <= '0;
                prod_q[l] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            sym_q        <= sym_d;
            pend_q       <= pend_d;
            pend_sym_q   <= pend_sym_d;
            cfg_done_q   <= cfg_done_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_ovf_q   <= dout_ovf_d;
            acc_q        <= acc_d;
            for (int l = 0; l < NMULT; l++) begin
                opx_q[l]  <= opx_d[l];
                opc_q[l]  <= opc_d[l];
                prod_q[l] <= prod_d[l];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NTAPS; k++) coef_q[k] <= '0;
        end else if (coef_we) begin
            coef_q[TAP_W'(cnt_q)] <= cfg_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || lines_clr) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NTAPS; k++) x_q[c][k] <= '0;
        end else if (shift_we) begin
            for (int k = NTAPS - 1; k > 0; k--) x_q[LCH_W'(din_ch)][k] <= x_q[LCH_W'(din_ch)][k-1];
            x_q[LCH_W'(din_ch)][0] <= din;
        end
    end
endmodule

// File: tb/tb_fir_mc_tdm_filter.sv
// Directed bench: small 5-tap, 2-channel, 2-multiplier build plus an 8-bit output twin for clipping.
module tb_fir_mc_tdm_filter;
    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               cfg_start = 1'b0, cfg_sym = 1'b0, cfg_valid = 1'b0;
    logic [23:0]        cfg_data = '0;
    logic signed [23:0] din = '0;
    logic [3:0]         din_ch = '0;
    logic               din_valid = 1'b0;
    logic               cfg_busy, cfg_done, din_ready, dout_valid, dout_ovf;
    logic [23:0]        dout;
    logic [3:0]         dout_ch;
    logic [2:0]         dbg_state;
    logic               cfg_busy8, cfg_done8, din_ready8, dout_valid8, dout_ovf8;
    logic [7:0]         dout8;
    logic [3:0]         dout_ch8;
    logic [2:0]         dbg_state8;

    int checks = 0;
    int errors = 0;
    logic [23:0] cw [0:7];
    logic [7:0]  cap8;
    logic        cap_ovf8;

    fir_mc_tdm_filter #(.DATA_W(24), .COEF_W(24), .OUT_W(24), .ACC_W(64), .NTAPS(5), .NCH(2),
                        .CH_W(4), .NMULT(2), .OUT_SHIFT(0)) dut (
        .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_sym(cfg_sym), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .din(din), .din_ch(din_ch),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ovf(dout_ovf), .dbg_state(dbg_state));

    fir_mc_tdm_filter #(.DATA_W(24), .COEF_W(24), .OUT_W(8), .ACC_W(64), .NTAPS(5), .NCH(2),
                        .CH_W(4), .NMULT(2), .OUT_SHIFT(0)) dut8 (
        .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_sym(cfg_sym), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_busy(cfg_busy8), .cfg_done(cfg_done8), .din(din), .din_ch(din_ch),
        .din_valid(din_valid), .din_ready(din_ready8), .dout(dout8), .dout_ch(dout_ch8),
        .dout_valid(dout_valid8), .dout_ovf(dout_ovf8), .dbg_state(dbg_state8));

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic feed_words(input int n, input logic gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i == 1) begin
                cfg_valid = 1'b0;
                tick;
            end
            cfg_data  = cw[i];
            cfg_valid = 1'b1;
            tick;
        end
        cfg_valid = 1'b0;
        checks++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_done: done=%b busy=%b, required done=1 busy=0", cfg_done, cfg_busy);
        end
    endtask

    task automatic load(input logic sym, input int n, input logic gap);
        cfg_sym   = sym;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        cfg_sym   = 1'b0;
        checks++;
        if (cfg_busy !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_busy: busy=%b ready=%b, required busy=1 ready=0", cfg_busy, din_ready);
        end
        feed_words(n, gap);
    endtask

    task automatic send(input logic [3:0] ch, input logic signed [23:0] val, input int iter,
                        input logic signed [23:0] exp);
        int n;
        n = 0;
        while (din_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        din = val;
        din_ch = ch;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        n = 0;
        while (dout_valid !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        cap8 = dout8;
        cap_ovf8 = dout_ovf8;
        checks++;
        if (n != iter + 2) begin
            errors++;
            $display("FAIL latency ch%0d in=%0d: %0d cycles after accept, required %0d", ch, val, n, iter + 2);
        end
        checks++;
        if (dout !== exp || dout_ch !== ch || dout_ovf !== 1'b0) begin
            errors++;
            $display("FAIL dout ch%0d in=%0d: got %0d ch%0d ovf=%b, required %0d ch%0d ovf=0",
                     ch, val, $signed(dout), dout_ch, dout_ovf, exp, ch);
        end
        tick;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_out: ready=%b valid=%b, required ready=1 valid=0", din_ready, dout_valid);
        end
    endtask

    task automatic set_cw(input int a, input int b, input int c, input int d, input int e);
        cw[0] = 24'(a); cw[1] = 24'(b); cw[2] = 24'(c); cw[3] = 24'(d); cw[4] = 24'(e);
    endtask

    task automatic test_reset;
        int bad;
        RST = 1'b1;
        tick;
        tick;
        RST = 1'b0;
        checks++;
        if (din_ready !== 1'b0 || cfg_busy !== 1'b0 || cfg_done !== 1'b0 || dout_valid !== 1'b0 ||
            dout !== 24'd0 || dout_ch !== 4'd0 || dout_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b valid=%b dout=%0d ch=%0d ovf=%b, required all 0",
                     din_ready, cfg_busy, cfg_done, dout_valid, dout, dout_ch, dout_ovf);
        end
        bad = 0;
        din = 24'd5;
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (din_ready !== 1'b0 || dout_valid !== 1'b0) bad++;
        end
        din_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL uncfg_ignore: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_impulse;
        set_cw(1, 2, 3, 4, 5);
        load(1'b0, 5, 1'b1);
        send(4'd0, 24'sd1, 3, 24'sd1);
        for (int i = 2; i <= 5; i++) send(4'd0, 24'sd0, 3, 24'(i));
    endtask

    task automatic test_back_to_back;
        logic signed [23:0] exp1 [0:5];
        exp1[0] = 10; exp1[1] = 30; exp1[2] = 60; exp1[3] = 100; exp1[4] = 150; exp1[5] = 150;
        load(1'b0, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(4'd0, (i == 0) ? 24'sd1 : 24'sd0, 3, (i < 5) ? 24'(i + 1) : 24'sd0);
            send(4'd1, 24'sd10, 3, exp1[i]);
        end
    endtask

    task automatic test_symmetric;
        logic signed [23:0] exp [0:5];
        exp[0] = 1; exp[1] = 3; exp[2] = 6; exp[3] = 8; exp[4] = 9; exp[5] = 9;
        set_cw(1, 2, 3, 0, 0);
        load(1'b1, 3, 1'b1);
        for (int i = 0; i < 6; i++) send(4'd0, 24'sd1, 2, exp[i]);
    endtask

    task automatic test_clip;
        logic [7:0] e_pos, e_neg;
        logic       e_ovf;
`ifdef FIR_MC_ROUND_SAT_EN
        e_pos = 8'h7F; e_neg = 8'h80; e_ovf = 1'b1;
`else
        e_pos = 8'h01; e_neg = 8'hFF; e_ovf = 1'b0;
`endif
        set_cw(127, 0, 0, 0, 0);
        load(1'b0, 5, 1'b0);
        send(4'd1, 24'sd127, 3, 24'sd16129);
        checks++;
        if (cap8 !== e_pos || cap_ovf8 !== e_ovf) begin
            errors++;
            $display("FAIL clip_pos: dout8=%h ovf=%b, required %h ovf=%b", cap8, cap_ovf8, e_pos, e_ovf);
        end
        send(4'd1, -24'sd127, 3, -24'sd16129);
        checks++;
        if (cap8 !== e_neg || cap_ovf8 !== e_ovf) begin
            errors++;
            $display("FAIL clip_neg: dout8=%h ovf=%b, required %h ovf=%b", cap8, cap_ovf8, e_neg, e_ovf);
        end
    endtask

    task automatic test_reconfig;
        int n;
        din = 24'sd1;
        din_ch = 4'd0;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        n = 0;
        while (dout_valid !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        checks++;
        if (n != 4 || dout !== 24'd127 || dout_ch !== 4'd0) begin
            errors++;
            $display("FAIL reconfig_out: wait=%0d dout=%0d ch=%0d, required wait=4 dout=127 ch=0", n, dout, dout_ch);
        end
        tick;
        checks++;
        if (cfg_busy !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reconfig_cfg: busy=%b ready=%b, required busy=1 ready=0", cfg_busy, din_ready);
        end
        set_cw(2, 0, 0, 0, 0);
        feed_words(5, 1'b0);
        send(4'd0, 24'sd7, 3, 24'sd14);
    endtask

    task automatic test_reset_mid_mac;
        int bad;
        din = 24'sd5;
        din_ch = 4'd0;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        checks++;
        if (din_ready !== 1'b0 || cfg_busy !== 1'b0 || cfg_done !== 1'b0 || dout_valid !== 1'b0 ||
            dout !== 24'd0 || dout_ch !== 4'd0 || dout_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b busy=%b valid=%b dout=%0d, required all 0",
                     din_ready, cfg_busy, dout_valid, dout);
        end
        bad = 0;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (dout_valid !== 1'b0 || din_ready !== 1'b0) bad++;
        end
        din_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_bad_channel;
        int bad;
        set_cw(1, 2, 3, 4, 5);
        load(1'b0, 5, 1'b0);
        send(4'd0, 24'sd1, 3, 24'sd1);
        din = 24'sd99;
        din_ch = 4'd3;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (dout_valid !== 1'b0 || din_ready !== 1'b1) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bad_channel: %0d cycles with output or not ready, required 0", bad);
        end
        send(4'd0, 24'sd0, 3, 24'sd2);
        send(4'd1, 24'sd0, 3, 24'sd0);
    endtask

    initial begin
        test_reset;
        test_impulse;
        test_back_to_back;
        test_symmetric;
        test_clip;
        test_reconfig;
        test_reset_mid_mac;
        test_bad_channel;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
